// File: rtl/event_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : event_packetizer
// Description : Timestamps per-channel event codes, arbitrates them
//               round-robin into a record FIFO and streams each record as
//               three bytes over a valid/ready byte interface.
// Revision    : 1.0 - initial release
// ============================================================================
module event_packetizer #(
  parameter int NUM_UNITS  = 4,
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_UNITS-1:0]          spike_in,
  input  logic [2*NUM_UNITS-1:0]        event_in,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    drop_count,
  output logic                          overflow
);

  // Record layout: {spike, ch[1:0], code[1:0], ts}
  localparam int               c_AW   = $clog2(FIFO_DEPTH);
  localparam int               c_RW   = 5 + TS_WIDTH;
  localparam logic [c_AW:0]    c_FULL = (c_AW+1)'(FIFO_DEPTH);
  localparam logic [1:0]       c_LAST = 2'(NUM_UNITS-1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_S0   = 2'd1,
    ST_S1   = 2'd2,
    ST_S2   = 2'd3
  } state_t;

  logic [TS_WIDTH-1:0]  r_ts;
  logic [NUM_UNITS-1:0] r_pend_v;
  logic [c_RW-1:0]      r_pend_rec [NUM_UNITS];
  logic [1:0]           r_rr;
  logic [7:0]           r_drop;
  logic                 r_ovf;
  logic [c_RW-1:0]      r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]      r_wr;
  logic [c_AW-1:0]      r_rd;
  logic [c_AW:0]        r_count;
  logic [c_RW-1:0]      r_shift;
  state_t               r_state;
  state_t               w_state_nxt;

  logic                 w_grant_v;
  logic [1:0]           w_grant_ch;
  logic [NUM_UNITS-1:0] w_grant_oh;
  logic [c_RW-1:0]      w_grant_rec;
  logic [NUM_UNITS-1:0] w_act;
  logic [2:0]           w_drops;
  logic [8:0]           w_drop_sum;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_nonempty;

  assign fifo_count = r_count;
  assign drop_count = r_drop;
  assign overflow   = r_ovf;
  assign w_push     = w_grant_v;
  assign w_nonempty = (r_count != '0);
  assign w_drop_sum = {1'b0, r_drop} + {6'b0, w_drops};

  // Channel index base+off folded back into 0..NUM_UNITS-1.
  function automatic logic [1:0] f_chan(input logic [1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_UNITS) s = s - NUM_UNITS;
    return s[1:0];
  endfunction

  // Free-running timestamp, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ts <= '0;
    else     r_ts <= r_ts + TS_WIDTH'(1);
  end

  // Round-robin arbiter: walk backwards so the nearest pending channel to r_rr wins.
  always_comb begin
    w_grant_v  = 1'b0;
    w_grant_ch = '0;
    w_grant_oh = '0;
    for (int k = NUM_UNITS-1; k >= 0; k--) begin
      if ((r_count != c_FULL) && r_pend_v[f_chan(r_rr, k)]) begin
        w_grant_v  = 1'b1;
        w_grant_ch = f_chan(r_rr, k);
      end
    end
    w_grant_rec = r_pend_rec[w_grant_ch];
    w_grant_oh[w_grant_ch] = w_grant_v;
  end

  // Active channels and count of events lost to an occupied pending slot.
  always_comb begin
    w_drops = '0;
    w_act   = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_act[i] = (event_in[2*i +: 2] != 2'b00);
      if (w_act[i] && r_pend_v[i] && !w_grant_oh[i]) w_drops = w_drops + 3'd1;
    end
  end

  // Pending slots: a granted slot may be refilled on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_v <= '0;
      for (int i = 0; i < NUM_UNITS; i++) r_pend_rec[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (w_act[i] && (!r_pend_v[i] || w_grant_oh[i])) begin
          r_pend_v[i]   <= 1'b1;
          r_pend_rec[i] <= {spike_in[i], 2'(i), event_in[2*i +: 2], r_ts};
        end else if (w_grant_oh[i]) begin
          r_pend_v[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer, saturating drop counter and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr   <= '0;
      r_drop <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_grant_v) r_rr <= (w_grant_ch == c_LAST) ? 2'd0 : w_grant_ch + 2'd1;
      if (w_drops != '0) begin
        r_ovf  <= 1'b1;
        r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      end
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_grant_rec;
  end

  // FIFO pointers, occupancy and serializer shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_shift <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + c_AW'(1);
      if (w_pop) begin
        r_rd    <= r_rd + c_AW'(1);
        r_shift <= r_mem[r_rd];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_AW+1)'(1);
        2'b01:   r_count <= r_count - (c_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Serializer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Serializer next state, pop request and byte output.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_nonempty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_S0;
        end
      end
      ST_S0: begin
        out_valid = 1'b1;
        out_data  = {1'b1, r_shift[c_RW-1], r_shift[c_RW-2 -: 2], 2'b00,
                     r_shift[TS_WIDTH+1 -: 2]};
        if (out_ready) w_state_nxt = ST_S1;
      end
      ST_S1: begin
        out_valid = 1'b1;
        out_data  = r_shift[TS_WIDTH-1 -: 8];
        if (out_ready) w_state_nxt = ST_S2;
      end
      ST_S2: begin
        out_valid = 1'b1;
        out_data  = r_shift[7:0];
        if (out_ready) begin
          if (w_nonempty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_S0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_event_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_event_packetizer
// Description : Self-checking bench for event_packetizer: queue-based
//               reference model compared every cycle plus directed byte
//               sequences with hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_event_packetizer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] spike_in = '0;
  logic [7:0] event_in = '0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [3:0] fifo_count;
  logic [7:0] drop_count;
  logic       overflow;

  int n_chk = 0;
  int n_err = 0;

  event_packetizer #(.NUM_UNITS(4), .TS_WIDTH(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .spike_in(spike_in), .event_in(event_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       spike;
    logic [1:0] ch;
    logic [1:0] code;
    logic [15:0] ts;
  } rec_t;

  logic [15:0] m_ts;
  bit   [3:0]  m_pv;
  rec_t        m_pend [4];
  rec_t        m_fifo [$];
  bit          m_busy;
  int          m_k;
  rec_t        m_cur;
  int          m_rr;
  int          m_drop;
  bit          m_ovf;

  function automatic logic [7:0] rec_byte(input rec_t r, input int k);
    if (k == 0)      return {1'b1, r.spike, r.ch, 2'b00, r.code};
    else if (k == 1) return r.ts[15:8];
    else             return r.ts[7:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    int   sz;
    bit   pop, acc;
    int   g;
    rec_t grec, head;
    if (rst) begin
      m_ts = 0; m_pv = '0; m_fifo.delete(); m_busy = 0; m_k = 0;
      m_cur = '0; m_rr = 0; m_drop = 0; m_ovf = 0;
      for (int i = 0; i < 4; i++) m_pend[i] = '0;
    end else begin
      sz  = m_fifo.size();
      acc = m_busy && out_ready;
      pop = (sz > 0) && (!m_busy || (acc && m_k == 2));
      g = -1;
      if (sz < 8)
        for (int k = 0; k < 4; k++)
          if (g < 0 && m_pv[(m_rr + k) % 4]) g = (m_rr + k) % 4;
      grec = (g >= 0) ? m_pend[g] : '0;
      for (int i = 0; i < 4; i++) begin
        if (event_in[2*i +: 2] != 0) begin
          if (!m_pv[i] || g == i) begin
            m_pend[i] = '{spike: spike_in[i], ch: 2'(i), code: event_in[2*i +: 2], ts: m_ts};
            m_pv[i] = 1;
          end else begin
            if (m_drop < 255) m_drop++;
            m_ovf = 1;
          end
        end else if (g == i) begin
          m_pv[i] = 0;
        end
      end
      if (pop) head = m_fifo.pop_front();
      if (g >= 0) begin
        m_fifo.push_back(grec);
        m_rr = (g + 1) % 4;
      end
      if (pop) begin
        m_cur = head; m_k = 0; m_busy = 1;
      end else if (acc) begin
        if (m_k == 2) m_busy = 0;
        else m_k++;
      end
      m_ts = m_ts + 16'd1;
    end
  end

  // ---------------- per-cycle compare and byte log ----------------
  logic       s_valid = 1'b0;
  logic [7:0] s_data  = '0;
  logic [7:0] dut_log [$];
  logic [7:0] eq [$];

  always @(negedge clk) begin
    s_valid = out_valid;
    s_data  = out_data;
    if (!rst) begin
      chk("valid", 32'(out_valid), 32'(m_busy));
      if (m_busy) chk("data", 32'(out_data), 32'(rec_byte(m_cur, m_k)));
      chk("fifo_count", 32'(fifo_count), m_fifo.size());
      chk("drop_count", 32'(drop_count), m_drop);
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  always @(posedge clk) begin
    if (!rst && s_valid && out_ready) dut_log.push_back(s_data);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; spike_in = '0; event_in = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    dut_log.delete();
  endtask

  task automatic cmp_log(input string name, input int budget);
    int c;
    c = 0;
    while (dut_log.size() < eq.size() && c < budget) begin
      tick();
      c++;
    end
    chk({name, "_len"}, dut_log.size(), eq.size());
    foreach (eq[i]) if (i < dut_log.size()) chk(name, 32'(dut_log[i]), 32'(eq[i]));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset values
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_fifo", 32'(fifo_count), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_ovf", 32'(overflow), 0);

    // Single event ch2 code 01 spike 1 at first edge (ts=0)
    rst = 1'b0; dut_log.delete();
    event_in = 8'h10; spike_in = 4'b0100; out_ready = 1'b1;
    tick(); event_in = '0; spike_in = '0;
    tick(); chk("lat_valid_e1", 32'(out_valid), 0);
    tick(); chk("lat_valid_e2", 32'(out_valid), 1);
    chk("single_b0", 32'(out_data), 32'h E1);
    tick(); chk("single_b1", 32'(out_data), 32'h00);
    tick(); chk("single_b2", 32'(out_data), 32'h00);
    tick(); chk("single_idle", 32'(out_valid), 0);

    // Simultaneous events, all channels code 10 at ts=5
    do_reset();
    out_ready = 1'b1;
    repeat (5) tick();
    event_in = 8'hAA;
    tick(); event_in = '0;
    eq.delete();
    for (int c = 0; c < 4; c++) begin
      eq.push_back(8'h82 + 8'(c * 16)); eq.push_back(8'h00); eq.push_back(8'h05);
    end
    cmp_log("simul", 100);
    chk("simul_drop", 32'(drop_count), 0);

    // Backpressure during S1, event at ts=300 (0x012C), ch2 code 01 spike 0
    do_reset();
    out_ready = 1'b1;
    repeat (300) tick();
    event_in = 8'h10;
    tick(); event_in = '0;
    tick();
    tick(); chk("bp_b0", 32'(out_data), 32'hA1);
    tick(); chk("bp_b1", 32'(out_data), 32'h01);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_data", 32'(out_data), 32'h01);
    end
    out_ready = 1'b1;
    tick(); chk("bp_b2", 32'(out_data), 32'h2C);
    tick(); chk("bp_idle", 32'(out_valid), 0);
    eq.delete(); eq.push_back(8'hA1); eq.push_back(8'h01); eq.push_back(8'h2C);
    cmp_log("bp", 10);

    // FIFO full: ch0 code 01 spike 1 every 2nd cycle with out_ready low
    do_reset();
    for (int j = 0; j <= 10; j++) begin
      event_in = 8'h01; spike_in = 4'b0001;
      tick(); event_in = '0; spike_in = '0;
      tick();
    end
    chk("full_count", 32'(fifo_count), 8);
    chk("full_drop", 32'(drop_count), 1);
    chk("full_ovf", 32'(overflow), 1);
    out_ready = 1'b1;
    eq.delete();
    for (int j = 0; j < 10; j++) begin
      eq.push_back(8'hC1); eq.push_back(8'h00); eq.push_back(8'(2 * j));
    end
    cmp_log("full_drain", 200);
    chk("full_empty", 32'(fifo_count), 0);

    // Timestamp wrap: ch1 code 11 at ts=FFFF, ch3 code 01 at ts=0000
    do_reset();
    out_ready = 1'b1;
    repeat (65535) tick();
    event_in = 8'h0C;
    tick(); event_in = 8'h40;
    tick(); event_in = '0;
    eq.delete();
    eq.push_back(8'h93); eq.push_back(8'hFF); eq.push_back(8'hFF);
    eq.push_back(8'hB1); eq.push_back(8'h00); eq.push_back(8'h00);
    cmp_log("wrap", 50);

    // Asynchronous reset during S1 with a record still queued
    do_reset();
    out_ready = 1'b1;
    event_in = 8'h02;
    tick(); event_in = 8'h04;
    tick(); event_in = '0;
    tick();
    tick(); out_ready = 1'b0;
    chk("ar_pre_count", 32'(fifo_count), 1);
    chk("ar_pre_valid", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_count", 32'(fifo_count), 0);
    chk("ar_data", 32'(out_data), 0);
    tick();
    rst = 1'b0; dut_log.delete();
    event_in = 8'h30; spike_in = 4'b0100; out_ready = 1'b1;
    tick(); event_in = '0; spike_in = '0;
    eq.delete(); eq.push_back(8'hE3); eq.push_back(8'h00); eq.push_back(8'h00);
    cmp_log("ar_after", 20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
